freq_div_multi: RTL and testbench
=================================

# freq_div_multi

Parametrised multi-channel clock/tick divider. Each channel derives a divided waveform from the one system clock with a programmable period and high time (duty cycle), a one-cycle tick at the start of every period, and glitch-free reprogramming at period boundaries. It sits between control registers and downstream logic that needs slow enables or divided clock-like strobes.

## Interface
- CHANNELS, 4, number of independent divider channels
- CNT_W, 32, width of period, high-time and counter per channel
- DEF_PERIOD, 2, active period after reset
- DEF_HIGH, 1, active high time after reset
- i_clk  input  1  system clock; all logic on rising edge
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_enable  input  CHANNELS  per-channel run enable, level
- i_load  input  CHANNELS  per-channel load strobe, one cycle
- i_period  input  CHANNELS*CNT_W  requested period in i_clk cycles; channel c at [c*CNT_W +: CNT_W]
- i_high  input  CHANNELS*CNT_W  requested high time in cycles, same packing
- o_clk  output  CHANNELS  divided waveform, registered
- o_tick  output  CHANNELS  one-cycle pulse at period start, registered
- o_pending  output  CHANNELS  loaded values not yet applied

## Operation
- Per channel: active period P, active high H, counter cnt, pending P', H', pending flag.
- Effective period Pe = max(P, 2); values 0 and 1 clamp to 2.
- H = 0: o_clk constant 0. H >= Pe: o_clk constant 1. o_tick still pulses every Pe cycles.
- Enabled: cnt sequence 0,1,...,Pe-1,0,... ; o_clk = (cnt < H); o_tick = (cnt == 0).
- Disabled: cnt held 0, o_clk 0, o_tick 0.
- i_load captures i_period/i_high slices into pending and sets o_pending.
  - Channel disabled at load edge: applied to P/H directly; o_pending stays 0.
  - Enabled: applied at the next wrap (edge where cnt goes Pe-1 -> 0); o_pending clears that edge.
  - Load on the same edge as a wrap: applied at that wrap; o_pending stays 0.
  - Load while pending: overwrites pending values; one application only.
- Enable deasserted while pending: pending applied on the disabling edge; o_pending clears.
- Channels fully independent; no cross-channel ordering.

## Timing
- Reset (async, i_rst_n low): cnt 0, P=DEF_PERIOD, H=DEF_HIGH, pending cleared; o_clk 0, o_tick 0, o_pending 0. Release takes effect on next i_clk edge.
- Enable rising sampled at edge k: at edge k cnt<=0, o_tick<=1, o_clk<=(0<H). Edge k+n: cnt<=n mod Pe.
- So o_clk high exactly H cycles then low Pe-H cycles, first high cycle coincident with o_tick.
- Enable falling sampled at edge k: o_clk, o_tick 0 after edge k.
- Outputs registered, no combinational path input -> output.
- Load latency: disabled channel, new values govern the first period after enable; enabled channel, first full period after next wrap. No truncated or stretched high phase at switch-over.
- Counter compares full CNT_W bits; no overflow since cnt < Pe <= 2^CNT_W-1.

## Configuration
- FREQ_DIV_SYNC_EN defined: adds port i_sync input 1. i_sync high at edge k forces every enabled channel to cnt<=0, o_tick<=1 (phase alignment); pending values applied at that edge as a wrap. i_sync has priority over normal counting; disabled channels unaffected.
- Not defined: no i_sync port; channels free-run from their own enable edge.

## Structure
- Package freq_div_pkg: CNT_W default, MIN_PERIOD = 2, function clamping a period to MIN_PERIOD.
- Sub-module freq_div_channel: one counter, active/pending registers, output logic; top generates CHANNELS instances and slices the packed buses.

## Test plan
- Reset release, ch0 enabled, defaults -> o_clk 1,0,1,0..., o_tick every 2 cycles starting on first enabled edge.
- ch1 load P=5 H=2 while disabled, then enable -> o_clk 1,1,0,0,0 repeating, o_tick at cnt 0, o_pending never set.
- ch2 running P=4 H=1, load P=6 H=3 mid-period -> o_pending high until wrap, old period completes intact, then 6-cycle period with 3 high.
- Edge values: P=0 and P=1 -> behave as P=2; H=0 -> o_clk constant 0 with ticks; H=7 P=5 -> o_clk constant 1.
- Assert i_rst_n low mid-period with pending load -> outputs 0 immediately, after release P=2 H=1, pending discarded.
- FREQ_DIV_SYNC_EN: channels P=3 and P=5 free-running, pulse i_sync -> both o_tick 1 on same cycle, sequences realigned.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the multi-channel frequency divider.
// Periods below MIN_PERIOD are clamped so that every enabled period has at
// least one cycle at each counter value 0 and 1.
package freq_div_pkg;

    // Default width of the period, high-time and counter registers.
    localparam int unsigned CNT_W_DEF  = 32;

    // Widest counter the clamp helper handles; channels zero-extend into it.
    localparam int unsigned MAX_CNT_W  = 64;

    // Smallest effective period; requested 0 and 1 behave as this value.
    localparam int unsigned MIN_PERIOD = 2;

    typedef logic [MAX_CNT_W-1:0] cnt_max_t;

    // Channel control state. CH_PEND means a load is waiting for the next
    // period boundary; o_pending is decoded directly from it.
    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_RUN  = 2'd1,
        CH_PEND = 2'd2
    } ch_state_e;

    // Clamp a requested period to the smallest usable period.
    function automatic cnt_max_t clamp_period(input cnt_max_t period);
        if (period < cnt_max_t'(MIN_PERIOD)) begin
            return cnt_max_t'(MIN_PERIOD);
        end
        return period;
    endfunction

endpackage : freq_div_pkg

// File: rtl/freq_div_channel.sv
// One divider channel: period counter, active and pending period/high-time
// registers, and registered o_clk / o_tick / o_pending outputs.
// New settings only take effect at a period boundary (enable start, wrap,
// sync) or while the channel is idle, so the high phase is never truncated
// or stretched by reprogramming.
module freq_div_channel
    import freq_div_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned DEF_PERIOD = 2,
    parameter int unsigned DEF_HIGH   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic             i_sync,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_high,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pending
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] pper_q, pper_d;
    logic [CNT_W-1:0] phigh_q, phigh_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] per_eff;
    logic             running;
    logic             wrap;

    // Effective period of the active setting and the wrap condition.
    always_comb begin
        per_eff = CNT_W'(clamp_period(cnt_max_t'(per_q)));
        running = (state_q != CH_OFF);
        wrap    = running && (cnt_q == (per_eff - CNT_W'(1)));
    end

    // State, counter and setting registers; async active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= CH_OFF;
            cnt_q   <= '0;
            per_q   <= CNT_W'(DEF_PERIOD);
            high_q  <= CNT_W'(DEF_HIGH);
            pper_q  <= '0;
            phigh_q <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            high_q  <= high_d;
            pper_q  <= pper_d;
            phigh_q <= phigh_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state: boundary detection, setting application and counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        high_d  = high_q;
        pper_d  = pper_q;
        phigh_d = phigh_q;

        if (!i_enable) begin
            // Idle: counter parked at 0; any setting lands immediately.
            state_d = CH_OFF;
            cnt_d   = '0;
            if (i_load) begin
                per_d  = i_period;
                high_d = i_high;
            end else if (state_q == CH_PEND) begin
                per_d  = pper_q;
                high_d = phigh_q;
            end
        end else if (!running || wrap || i_sync) begin
            // Period boundary: restart at 0 and apply the newest setting.
            state_d = CH_RUN;
            cnt_d   = '0;
            if (i_load) begin
                per_d  = i_period;
                high_d = i_high;
            end else if (state_q == CH_PEND) begin
                per_d  = pper_q;
                high_d = phigh_q;
            end
        end else begin
            // Mid-period: count, and park a load until the next boundary.
            cnt_d = cnt_q + CNT_W'(1);
            if (i_load) begin
                pper_d  = i_period;
                phigh_d = i_high;
                state_d = CH_PEND;
            end
        end

        // Outputs follow the counter value being registered this edge.
        clk_d  = i_enable && (cnt_d < high_d);
        tick_d = i_enable && (cnt_d == '0);
    end

    assign o_clk     = clk_q;
    assign o_tick    = tick_q;
    assign o_pending = (state_q == CH_PEND);

endmodule : freq_div_channel

// File: rtl/freq_div_multi.sv
// Multi-channel clock/tick divider: CHANNELS independent freq_div_channel
// instances driven from packed period / high-time buses.
// Optional feature macro: FREQ_DIV_SYNC_EN adds the i_sync input, which
// restarts every enabled channel at counter 0 on the same edge.
module freq_div_multi
    import freq_div_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned DEF_PERIOD = 2,
    parameter int unsigned DEF_HIGH   = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS-1:0]       i_enable,
    input  logic [CHANNELS-1:0]       i_load,
    input  logic [CHANNELS*CNT_W-1:0] i_period,
    input  logic [CHANNELS*CNT_W-1:0] i_high,
`ifdef FREQ_DIV_SYNC_EN
    input  logic                      i_sync,
`endif
    output logic [CHANNELS-1:0]       o_clk,
    output logic [CHANNELS-1:0]       o_tick,
    output logic [CHANNELS-1:0]       o_pending
);

    logic sync_w;

`ifdef FREQ_DIV_SYNC_EN
    assign sync_w = i_sync;
`else
    assign sync_w = 1'b0;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        freq_div_channel #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_enable  (i_enable[c]),
            .i_load    (i_load[c]),
            .i_sync    (sync_w),
            .i_period  (i_period[c*CNT_W +: CNT_W]),
            .i_high    (i_high[c*CNT_W +: CNT_W]),
            .o_clk     (o_clk[c]),
            .o_tick    (o_tick[c]),
            .o_pending (o_pending[c])
        );
    end

endmodule : freq_div_multi

// File: tb/tb_freq_div_multi.sv
// Directed bench for freq_div_multi. Each cycle the driver pushes the
// hand-computed expected outputs for the selected channels; the monitor pops
// one entry after every rising edge and compares the masked outputs.
module tb_freq_div_multi;

    localparam int CH = 4;
    localparam int W  = 32;

    logic            clk;
    logic            rst_n;
    logic [CH-1:0]   enable;
    logic [CH-1:0]   load;
    logic [CH*W-1:0] period;
    logic [CH*W-1:0] high;
    logic            sync;
    logic [CH-1:0]   o_clk;
    logic [CH-1:0]   o_tick;
    logic [CH-1:0]   o_pending;

    int checks = 0;
    int errors = 0;

    // Expected entry: {mask, clk, tick, pending}, 4 bits each.
    logic [15:0] exp_q[$];
    string       name_q[$];

    freq_div_multi #(
        .CHANNELS   (CH),
        .CNT_W      (W),
        .DEF_PERIOD (2),
        .DEF_HIGH   (1)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_enable  (enable),
        .i_load    (load),
        .i_period  (period),
        .i_high    (high),
`ifdef FREQ_DIV_SYNC_EN
        .i_sync    (sync),
`endif
        .o_clk     (o_clk),
        .o_tick    (o_tick),
        .o_pending (o_pending)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Monitor: one expected entry per rising edge when available.
    always @(posedge clk) begin
        logic [15:0] e;
        logic [3:0]  m;
        logic [11:0] act;
        logic [11:0] expv;
        string       nm;
        #1;
        if (exp_q.size() != 0) begin
            e    = exp_q.pop_front();
            nm   = name_q.pop_front();
            m    = e[15:12];
            act  = {o_clk & m, o_tick & m, o_pending & m};
            expv = {e[11:8] & m, e[7:4] & m, e[3:0] & m};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL %s @%0t: clk/tick/pend got %b/%b/%b expected %b/%b/%b",
                         nm, $time, act[11:8], act[7:4], act[3:0],
                         expv[11:8], expv[7:4], expv[3:0]);
            end
        end
    end

    // Driver helpers.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [3:0] m, input logic [3:0] c,
                       input logic [3:0] t, input logic [3:0] p);
        exp_q.push_back({m, c, t, p});
        name_q.push_back(nm);
        cyc();
    endtask

    task automatic chk1(input string nm, input int ch, input logic c,
                        input logic t, input logic p);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        chk(nm, oh, c ? oh : 4'b0000, t ? oh : 4'b0000, p ? oh : 4'b0000);
    endtask

    task automatic set_cfg(input int ch, input int p, input int h);
        period[ch*W +: W] = p;
        high[ch*W +: W]   = h;
    endtask

    task automatic chk_zero(input string nm);
        checks++;
        if (o_clk !== '0 || o_tick !== '0 || o_pending !== '0) begin
            errors++;
            $display("FAIL %s @%0t: clk/tick/pend got %b/%b/%b expected 0000/0000/0000",
                     nm, $time, o_clk, o_tick, o_pending);
        end
    endtask

    // Directed stimulus.
    initial begin
        rst_n  = 1'b0;
        enable = '0;
        load   = '0;
        period = '0;
        high   = '0;
        sync   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset_state");
        rst_n = 1'b1;
        cyc();

        // ch0 defaults P=2 H=1.
        enable[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk1("ch0_default", 0, (i % 2) == 0, (i % 2) == 0, 1'b0);
        end

        // ch0 load on the wrap edge: applied at once, no pending.
        set_cfg(0, 3, 2);
        load[0] = 1'b1;
        chk1("ch0_wrap_load", 0, 1'b1, 1'b1, 1'b0);
        load[0] = 1'b0;
        chk1("ch0_wrap_load", 0, 1'b1, 1'b0, 1'b0);
        chk1("ch0_wrap_load", 0, 1'b0, 1'b0, 1'b0);
        chk1("ch0_wrap_load", 0, 1'b1, 1'b1, 1'b0);

        // ch1 load while disabled, then enable: P=5 H=2.
        set_cfg(1, 5, 2);
        load[1] = 1'b1;
        chk1("ch1_idle_load", 1, 1'b0, 1'b0, 1'b0);
        load[1] = 1'b0;
        enable[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk1("ch1_p5h2", 1, (i % 5) < 2, (i % 5) == 0, 1'b0);
        end

        // ch1 double load while pending: second one wins (P=4 H=3).
        chk1("ch1_overwrite", 1, 1'b1, 1'b1, 1'b0);
        set_cfg(1, 3, 1);
        load[1] = 1'b1;
        chk1("ch1_overwrite", 1, 1'b1, 1'b0, 1'b1);
        set_cfg(1, 4, 3);
        chk1("ch1_overwrite", 1, 1'b0, 1'b0, 1'b1);
        load[1] = 1'b0;
        chk1("ch1_overwrite", 1, 1'b0, 1'b0, 1'b1);
        chk1("ch1_overwrite", 1, 1'b0, 1'b0, 1'b1);
        chk1("ch1_p4h3", 1, 1'b1, 1'b1, 1'b0);
        chk1("ch1_p4h3", 1, 1'b1, 1'b0, 1'b0);
        chk1("ch1_p4h3", 1, 1'b1, 1'b0, 1'b0);
        chk1("ch1_p4h3", 1, 1'b0, 1'b0, 1'b0);
        chk1("ch1_p4h3", 1, 1'b1, 1'b1, 1'b0);

        // ch2 running P=4 H=1, reprogram mid-period to P=6 H=3.
        set_cfg(2, 4, 1);
        load[2] = 1'b1;
        chk1("ch2_idle_load", 2, 1'b0, 1'b0, 1'b0);
        load[2] = 1'b0;
        enable[2] = 1'b1;
        chk1("ch2_p4h1", 2, 1'b1, 1'b1, 1'b0);
        chk1("ch2_p4h1", 2, 1'b0, 1'b0, 1'b0);
        set_cfg(2, 6, 3);
        load[2] = 1'b1;
        chk1("ch2_pending", 2, 1'b0, 1'b0, 1'b1);
        load[2] = 1'b0;
        chk1("ch2_pending", 2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk1("ch2_p6h3", 2, (i % 6) < 3, (i % 6) == 0, 1'b0);
        end

        // ch2 disable while pending: applied on the disabling edge.
        set_cfg(2, 2, 1);
        load[2] = 1'b1;
        chk1("ch2_dis_pend", 2, 1'b1, 1'b0, 1'b1);
        load[2] = 1'b0;
        enable[2] = 1'b0;
        chk1("ch2_disable", 2, 1'b0, 1'b0, 1'b0);
        enable[2] = 1'b1;
        chk1("ch2_p2h1", 2, 1'b1, 1'b1, 1'b0);
        chk1("ch2_p2h1", 2, 1'b0, 1'b0, 1'b0);
        chk1("ch2_p2h1", 2, 1'b1, 1'b1, 1'b0);

        // ch3 boundary settings.
        set_cfg(3, 0, 1);
        load[3] = 1'b1;
        chk1("ch3_p0_load", 3, 1'b0, 1'b0, 1'b0);
        load[3] = 1'b0;
        enable[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk1("ch3_p0", 3, (i % 2) == 0, (i % 2) == 0, 1'b0);
        end
        enable[3] = 1'b0;
        chk1("ch3_off", 3, 1'b0, 1'b0, 1'b0);

        set_cfg(3, 1, 1);
        load[3] = 1'b1;
        chk1("ch3_p1_load", 3, 1'b0, 1'b0, 1'b0);
        load[3] = 1'b0;
        enable[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk1("ch3_p1", 3, (i % 2) == 0, (i % 2) == 0, 1'b0);
        end
        enable[3] = 1'b0;
        chk1("ch3_off", 3, 1'b0, 1'b0, 1'b0);

        set_cfg(3, 3, 0);
        load[3] = 1'b1;
        chk1("ch3_h0_load", 3, 1'b0, 1'b0, 1'b0);
        load[3] = 1'b0;
        enable[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk1("ch3_h0", 3, 1'b0, (i % 3) == 0, 1'b0);
        end
        enable[3] = 1'b0;
        chk1("ch3_off", 3, 1'b0, 1'b0, 1'b0);

        set_cfg(3, 5, 7);
        load[3] = 1'b1;
        chk1("ch3_h7_load", 3, 1'b0, 1'b0, 1'b0);
        load[3] = 1'b0;
        enable[3] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk1("ch3_h7p5", 3, 1'b1, (i % 5) == 0, 1'b0);
        end
        enable[3] = 1'b0;
        chk1("ch3_off", 3, 1'b0, 1'b0, 1'b0);

        // Reset mid-period with a pending load on ch1.
        set_cfg(1, 7, 5);
        load[1] = 1'b1;
        chk1("ch1_pre_reset", 1, 1'b1, 1'b0, 1'b1);
        load[1] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        // ch0 and ch1 still enabled: both restart with P=2 H=1.
        chk("post_reset", 4'b0011, 4'b0011, 4'b0011, 4'b0000);
        chk("post_reset", 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        chk("post_reset", 4'b0011, 4'b0011, 4'b0011, 4'b0000);
        chk("post_reset", 4'b0011, 4'b0000, 4'b0000, 4'b0000);

`ifdef FREQ_DIV_SYNC_EN
        // Phase alignment of ch0 (P=3) and ch3 (P=5).
        enable = '0;
        cyc();
        set_cfg(0, 3, 1);
        set_cfg(3, 5, 1);
        load = 4'b1001;
        cyc();
        load = '0;
        enable[0] = 1'b1;
        cyc();
        cyc();
        enable[3] = 1'b1;
        cyc();
        cyc();
        sync = 1'b1;
        chk("sync_align", 4'b1001, 4'b1001, 4'b1001, 4'b0000);
        sync = 1'b0;
        chk("sync_after", 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        chk("sync_after", 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        chk("sync_after", 4'b1001, 4'b0001, 4'b0001, 4'b0000);
`endif

        cyc();
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_freq_div_multi
